// File: rtl/write_resp_router_pkg.sv
// write_resp_router_pkg: shared interconnect master ids, BRESP codes and default tracking depth
package write_resp_router_pkg;
  localparam logic MASTER_S00 = 1'b0;
  localparam logic MASTER_S01 = 1'b1;
  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;
  localparam int DEFAULT_DEPTH = 4;
endpackage

// File: rtl/write_resp_router_resp_id_fifo.sv
// resp_id_fifo: in-order master-id FIFO (push/pop in, head_id/cnt/full/empty out), full-push dropped
module resp_id_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic push_ok, pop_ok;
  assign full = cnt_q == CNT_W'(DEPTH);
  assign empty = cnt_q == '0;
  assign cnt = cnt_q;
  assign head_id = mem_q[rd_ptr_q];
  always_comb begin
    push_ok = push && !full;
    pop_ok = pop && !empty;
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_id;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      mem_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/write_resp_router.sv
// write_resp_router: routes slave B responses to the AW-granted master (S00/S01) in issue order
module write_resp_router
  import write_resp_router_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             aw_grant_valid,
  input  logic             aw_grant_master,
  output logic             aw_stall,
  input  logic             M_AXI_bvalid,
  input  logic [1:0]       M_AXI_bresp,
  output logic             M_AXI_bready,
  output logic             Selected_Slave,
  input  logic             Sele_S_AXI_bready,
  output logic             S00_AXI_bvalid,
  output logic [1:0]       S00_AXI_bresp,
  output logic             S01_AXI_bvalid,
  output logic [1:0]       S01_AXI_bresp,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             err_orphan_b
);
  logic empty, full, head, pop, to_s00, to_s01;
  logic err_orphan_b_d, err_orphan_b_q;
  resp_id_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk(ACLK),
    .rst_n(ARESETN),
    .push(aw_grant_valid),
    .push_id(aw_grant_master),
    .pop(pop),
    .head_id(head),
    .cnt(outstanding_cnt),
    .full(full),
    .empty(empty)
  );
  assign aw_stall = full;
  assign err_orphan_b = err_orphan_b_q;
  always_comb begin
    to_s00 = !empty && head == MASTER_S00;
    to_s01 = !empty && head == MASTER_S01;
    M_AXI_bready = Sele_S_AXI_bready && !empty;
    Selected_Slave = empty ? MASTER_S00 : head;
    S00_AXI_bvalid = to_s00 && M_AXI_bvalid;
    S01_AXI_bvalid = to_s01 && M_AXI_bvalid;
    S00_AXI_bresp = to_s00 ? M_AXI_bresp : BRESP_OKAY;
    S01_AXI_bresp = to_s01 ? M_AXI_bresp : BRESP_OKAY;
    pop = M_AXI_bvalid && M_AXI_bready;
    err_orphan_b_d = err_orphan_b_q || (M_AXI_bvalid && empty);
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) err_orphan_b_q <= 1'b0;
    else err_orphan_b_q <= err_orphan_b_d;
  end
endmodule

// File: tb/tb_write_resp_router.sv
// tb_write_resp_router: randomized + directed scoreboard bench against a queue model of tracked writes
module tb_write_resp_router;
  import write_resp_router_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic aw_grant_valid = 1'b0, aw_grant_master = 1'b0;
  logic M_AXI_bvalid = 1'b0, Sele_S_AXI_bready = 1'b0;
  logic [1:0] M_AXI_bresp = 2'b00;
  logic aw_stall, M_AXI_bready, Selected_Slave, S00_AXI_bvalid, S01_AXI_bvalid, err_orphan_b;
  logic [1:0] S00_AXI_bresp, S01_AXI_bresp;
  logic [CNT_W-1:0] outstanding_cnt;
  typedef struct packed {logic m; logic [1:0] r;} resp_t;
  bit mq[$];
  resp_t exp_q[$];
  bit err_m = 1'b0;
  int checks = 0, failures = 0;

  write_resp_router #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .aw_grant_valid(aw_grant_valid), .aw_grant_master(aw_grant_master), .aw_stall(aw_stall),
    .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bresp(M_AXI_bresp), .M_AXI_bready(M_AXI_bready),
    .Selected_Slave(Selected_Slave), .Sele_S_AXI_bready(Sele_S_AXI_bready),
    .S00_AXI_bvalid(S00_AXI_bvalid), .S00_AXI_bresp(S00_AXI_bresp),
    .S01_AXI_bvalid(S01_AXI_bvalid), .S01_AXI_bresp(S01_AXI_bresp),
    .outstanding_cnt(outstanding_cnt), .err_orphan_b(err_orphan_b)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  // one bus cycle: drive at negedge, check combinational routing, advance model, check registers after posedge
  task automatic cycle(input bit gv, input bit gm, input bit bv, input logic [1:0] br, input bit sb);
    int sz;
    bit e, h;
    logic [5:0] ro;
    @(negedge ACLK);
    aw_grant_valid = gv; aw_grant_master = gm;
    M_AXI_bvalid = bv; M_AXI_bresp = br; Sele_S_AXI_bready = sb;
    #1;
    sz = mq.size();
    e = sz == 0;
    h = e ? 1'b0 : mq[0];
    ro = {!e && !h && bv, (!e && !h) ? br : 2'b00, !e && h && bv, (!e && h) ? br : 2'b00};
    chk("route", {26'd0, S00_AXI_bvalid, S00_AXI_bresp, S01_AXI_bvalid, S01_AXI_bresp}, {26'd0, ro});
    chk("sel", {31'd0, Selected_Slave}, {31'd0, h});
    chk("bready", {31'd0, M_AXI_bready}, {31'd0, sb && !e});
    if (bv && sb && !e) begin
      exp_q.push_back(resp_t'({h, br}));
      void'(mq.pop_front());
    end
    if (bv && e) err_m = 1'b1;
    if (gv && sz < DEPTH) mq.push_back(gm);
    @(posedge ACLK);
    #1;
    chk("cnt", {29'd0, outstanding_cnt}, mq.size());
    chk("stall", {31'd0, aw_stall}, {31'd0, mq.size() == DEPTH});
    chk("err", {31'd0, err_orphan_b}, {31'd0, err_m});
  endtask

  task automatic do_reset(input bit bv);
    @(negedge ACLK);
    M_AXI_bvalid = bv; Sele_S_AXI_bready = bv; aw_grant_valid = 1'b0;
    #1;
    ARESETN = 1'b0;
    #1;
    chk("reset_outs", {25'd0, outstanding_cnt, aw_stall, err_orphan_b, M_AXI_bready, Selected_Slave, S00_AXI_bvalid, S01_AXI_bvalid}, 32'd0);
    mq.delete();
    exp_q.delete();
    err_m = 1'b0;
    M_AXI_bvalid = 1'b0; Sele_S_AXI_bready = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  // monitor: every B handshake the DUT presents must match the next expected routed response
  initial forever begin
    resp_t r;
    @(negedge ACLK);
    #2;
    if (M_AXI_bvalid && M_AXI_bready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mon_unexpected_pop actual=handshake expected=none at %0t", $time);
      end else begin
        r = exp_q.pop_front();
        chk("mon_sel", {31'd0, Selected_Slave}, {31'd0, r.m});
        chk("mon_route", {26'd0, S00_AXI_bvalid, S00_AXI_bresp, S01_AXI_bvalid, S01_AXI_bresp},
            {26'd0, r.m ? {3'b000, 1'b1, r.r} : {1'b1, r.r, 3'b000}});
      end
    end
  end

  initial begin
    do_reset(1'b0);
    cycle(1, 1, 0, 2'b00, 0);
    cycle(1, 0, 0, 2'b00, 0);
    cycle(0, 0, 1, BRESP_SLVERR, 1);
    cycle(0, 0, 1, BRESP_EXOKAY, 1);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 2'b00, 0);
    cycle(1, 1, 0, 2'b00, 0);
    cycle(1, 1, 1, BRESP_OKAY, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, BRESP_DECERR, 1);
    cycle(0, 0, 1, BRESP_OKAY, 1);
    cycle(0, 0, 0, BRESP_OKAY, 0);
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, i[0] ^ i[2], 0, 2'b00, 0);
      cycle(0, 0, 1, 2'(i), 1);
    end
    for (int i = 0; i < 3; i++) cycle(1, i[0], 0, 2'b00, 0);
    do_reset(1'b1);
    cycle(0, 0, 1, BRESP_OKAY, 1);
    cycle(0, 0, 0, BRESP_OKAY, 0);
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1'b0);
      cycle($urandom_range(0, 9) < 6, 1'($urandom), $urandom_range(0, 9) < 5, 2'($urandom), $urandom_range(0, 9) < 7);
    end
    cycle(0, 0, 0, 2'b00, 0);
    chk("drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/write_resp_router.md
WRITE_RESP_ROUTER -- requirements
Module: write_resp_router

Interface
REQ-001 Parameter DEPTH, default 4, number of outstanding write transactions tracked (power of two, 2..16).
REQ-002 Parameter CNT_W, default 3, width of outstanding count; SHALL equal clog2(DEPTH)+1.
REQ-003 ACLK  in  1  single clock; all state updates on rising edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 aw_grant_valid  in  1  AW handshake to the slave completed this cycle.
REQ-006 aw_grant_master  in  1  master owning that AW (0=S00, 1=S01).
REQ-007 aw_stall  out  1  tracking FIFO full; AW arbiter SHALL NOT grant while high.
REQ-008 M_AXI_bvalid  in  1  write response valid from slave.
REQ-009 M_AXI_bresp  in  2  write response code from slave.
REQ-010 M_AXI_bready  out  1  ready returned to slave.
REQ-011 Selected_Slave  out  1  master owning the head response; drives BReady mux select.
REQ-012 Sele_S_AXI_bready  in  1  muxed bready from BReady mux.
REQ-013 S00_AXI_bvalid / S01_AXI_bvalid  out  1 each  routed response valid per master.
REQ-014 S00_AXI_bresp / S01_AXI_bresp  out  2 each  routed response code per master.
REQ-015 outstanding_cnt  out  CNT_W  number of tracked, unanswered writes.
REQ-016 err_orphan_b  out  1  sticky: bvalid seen with no write outstanding.

Function
REQ-017 Block SHALL hold an in-order FIFO of master indices, DEPTH entries, read/write pointers wrapping modulo DEPTH.
REQ-018 Push: aw_grant_valid=1 and not full -> write aw_grant_master at write pointer, pointer +1.
REQ-019 Push while full SHALL be dropped, FIFO unchanged, err_orphan_b unaffected.
REQ-020 aw_stall SHALL equal (outstanding_cnt == DEPTH), registered state only, no combinational path from aw_grant_valid.
REQ-021 Selected_Slave SHALL equal head entry when non-empty, 0 when empty.
REQ-022 Non-empty: Sxx_AXI_bvalid of head master = M_AXI_bvalid, other = 0; head master bresp = M_AXI_bresp, other = 2'b00.
REQ-023 Empty: both Sxx_AXI_bvalid = 0, both bresp = 2'b00, M_AXI_bready = 0.
REQ-024 M_AXI_bready SHALL equal Sele_S_AXI_bready AND not empty (combinational).
REQ-025 Pop: M_AXI_bvalid AND M_AXI_bready -> read pointer +1; Selected_Slave advances the following cycle.
REQ-026 Simultaneous push and pop, non-empty: both SHALL occur, count unchanged.
REQ-027 Push into empty FIFO: entry becomes head the next cycle; no same-cycle bypass to B outputs.
REQ-028 Simultaneous push and pop, full: pop occurs, push dropped per REQ-019.
REQ-029 outstanding_cnt: +1 on push only, -1 on pop only, unchanged otherwise; never exceeds DEPTH, never below 0.
REQ-030 M_AXI_bvalid=1 while empty SHALL set err_orphan_b the next edge; it clears only on reset.
REQ-031 Latency: AW grant to routable response = 1 cycle; B path is combinational (0 cycles).

Reset
REQ-032 ARESETN low SHALL immediately clear pointers, outstanding_cnt, err_orphan_b; Selected_Slave=0, aw_stall=0, M_AXI_bready=0, all Sxx bvalid=0.
REQ-033 Reset mid-transaction SHALL discard all tracked entries; no response routed after release until a new push.
REQ-034 Reset deassertion is synchronous to ACLK externally; block adds no synchronizer.

Structure
REQ-035 Shared interconnect package SHALL hold MASTER_S00=0, MASTER_S01=1, BRESP encodings (OKAY, EXOKAY, SLVERR, DECERR) and default DEPTH.
REQ-036 FIFO storage and pointers SHALL be one sub-module, resp_id_fifo; routing logic in top.

Verification
REQ-037 Reset, then push S01, S00 -> cycle after: cnt=2, Selected_Slave=1; bvalid=1, bresp=SLVERR, Sele bready=1 -> S01 bvalid=1 bresp=2'b10, S00 bvalid=0; next cycle Selected_Slave=0, cnt=1.
REQ-038 DEPTH=4, four pushes -> aw_stall=1, cnt=4; fifth push -> dropped, cnt=4; one pop -> aw_stall=0 next cycle.
REQ-039 Full FIFO with simultaneous push and pop -> cnt=3, pushed master absent from subsequent pop order.
REQ-040 Empty FIFO, M_AXI_bvalid=1, Sele bready=1 -> M_AXI_bready=0, both Sxx bvalid=0, err_orphan_b=1 next cycle and stays 1.
REQ-041 Eight alternating push/pop cycles (pointer wrap) -> pop order matches push order, cnt returns to 0.
REQ-042 ARESETN low with cnt=3 while bvalid high -> outputs cleared same cycle; after release, bvalid=1 -> no routing, err_orphan_b=1.
